flowid_allocator: RTL and testbench
===================================

# flowid_allocator

Parametrised flow-ID allocator for the TCP slow path, successor to the fixed-width flow-ID manager. It hands out IDs 0..NUM_FLOWIDS-1 in order after reset, then recycles returned IDs through a free-list FIFO. It replaces the request/avail pulse with a proper valid/ready handshake and tracks in-use count. An optional in-use bitmap rejects double-frees and out-of-range returns. It sits between connection setup (allocate) and connection teardown (return) logic.

## Interface
- FLOWID_W, default 8: ID width in bits.
- NUM_FLOWIDS, default 2**FLOWID_W: number of managed IDs, 1..2**FLOWID_W.
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- alloc_val  output  1  an ID is offered on alloc_id.
- alloc_id  output  FLOWID_W  offered ID.
- alloc_rdy  input  1  consumer takes the ID when alloc_val & alloc_rdy.
- ret_val  input  1  returned ID present.
- ret_id  input  FLOWID_W  returned ID.
- ret_rdy  output  1  return accepted when ret_val & ret_rdy.
- inuse_cnt  output  FLOWID_W+1  number of IDs currently allocated.
- ret_err  output  1  one-cycle pulse: previous-cycle return rejected (checker builds only).

## Operation
- State: fresh_ctr (FLOWID_W+1 bits), free-list FIFO (depth 2**FLOWID_W), inuse_cnt, optional bitmap.
- Source select is combinational from registered state. While fresh_ctr < NUM_FLOWIDS: alloc_val=1, alloc_id=fresh_ctr[FLOWID_W-1:0]. Otherwise: alloc_val=~fifo_empty, alloc_id=FIFO head.
- Once fresh IDs are exhausted the block stays in FIFO mode until reset. It never drops back to the counter.
- Alloc handshake: in fresh mode, increment fresh_ctr. In FIFO mode, pop the FIFO.
- alloc_val and alloc_id never depend on alloc_rdy.
- While alloc_val=1 and alloc_rdy=0, alloc_id stays stable.
- Return path: ret_rdy=~fifo_full. An accepted, valid return is pushed into the FIFO.
- Under legal use the FIFO never fills, because depth ≥ NUM_FLOWIDS.
- inuse_cnt:
  - +1 on alloc handshake.
  - −1 on an accepted, non-rejected return.
  - Unchanged when both happen in the same cycle.
  - Saturates at 0; never underflows.
- Simultaneous alloc and return: both complete. The returned ID is not bypassed to alloc_id in the same cycle.

## Timing
- Reset values: fresh_ctr=0, FIFO empty, inuse_cnt=0, ret_err=0, bitmap all 0.
- Outputs during and just after reset: alloc_val=1, alloc_id=0, ret_rdy=1.
- Allocation latency is 0: an ID is offered combinationally every cycle alloc_val=1. Throughput is one allocation per cycle.
- Return-to-reuse latency: an ID returned in cycle N can be offered on alloc_id no earlier than cycle N+1 (fifo_1r1w write-to-read latency).
- ret_err is registered: it asserts in cycle N+1 for a rejected return in cycle N.
- Asynchronous reset mid-operation:
  - All state clears immediately.
  - Any in-flight handshake in that cycle is discarded.
  - Allocation restarts at ID 0.

## Configuration
- FLOWID_ALLOC_CHECK_EN defined:
  - Keep an NUM_FLOWIDS-bit in-use bitmap. Set the bit on alloc handshake; clear it on accepted return.
  - A return is rejected if ret_id ≥ NUM_FLOWIDS or its bit is clear in the registered bitmap.
  - For a rejected return: ret_rdy is still 1 (the return is consumed), there is no FIFO push, inuse_cnt is unchanged, and ret_err pulses.
  - An alloc and a return of the same ID in one cycle is rejected, because the check uses the pre-cycle bitmap.
- FLOWID_ALLOC_CHECK_EN undefined:
  - No bitmap; every accepted return is pushed.
  - ret_err is tied to 0.

## Structure
- tcp_pkg: FLOWID_W default constant and a flowid_t typedef.
- Sub-module: fifo_1r1w free list, with width_p=FLOWID_W, log2_els_p=FLOWID_W, and rst driven by ~rst_n.
- All counter and select logic is inline in flowid_allocator.

## Test plan
- Reset, alloc_rdy=1 for NUM_FLOWIDS=4 (FLOWID_W=2) → IDs 0,1,2,3 on consecutive cycles; then alloc_val=0; inuse_cnt=4.
- After exhaustion, return 2 then 0 → alloc_val rises one cycle after the first return; IDs offered are 2 then 0; inuse_cnt goes 4→3→2→3→4.
- alloc_rdy=0 for 5 cycles while alloc_val=1 → alloc_id stays at the same value; fresh_ctr does not advance.
- Same-cycle alloc of ID 3 and return of ID 1 (ID 1 in use) → both complete; inuse_cnt unchanged; next alloc_id is 1.
- With FLOWID_ALLOC_CHECK_EN: return ID 1 twice, then return ID 5 with NUM_FLOWIDS=4 → first return accepted; second and third each give a ret_err pulse the following cycle; no FIFO push; inuse_cnt changes only once.
- Assert rst_n low mid-stream with 3 IDs allocated → inuse_cnt=0 and alloc_id=0 immediately; on release, allocation resumes from ID 0.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared TCP slow-path types: default flow-ID width and the flow-ID type.
package tcp_pkg;
    localparam int TCP_FLOWID_W = 8;
    typedef logic [TCP_FLOWID_W-1:0] flowid_t;
endpackage

// File: rtl/fifo_1r1w.sv
// Purpose: single-clock one-read/one-write FIFO, 2**log2_els_p entries.
// Latency: a write is visible at the read port the following cycle.
// Backpressure: writes dropped while full, pops ignored while empty.
module fifo_1r1w #(
    parameter int width_p    = 8,
    parameter int log2_els_p = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_v_i,
    input  logic [width_p-1:0] w_data_i,
    output logic               w_full_o,
    input  logic               r_yumi_i,
    output logic [width_p-1:0] r_data_o,
    output logic               r_empty_o
);
    localparam logic [log2_els_p:0] ONE_C = (log2_els_p+1)'(1);

    logic [width_p-1:0]  r_mem [2**log2_els_p];
    logic [log2_els_p:0] r_wptr;
    logic [log2_els_p:0] r_rptr;
    logic                w_wr;
    logic                w_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign r_empty_o = (r_wptr == r_rptr);
    assign w_full_o  = (r_wptr[log2_els_p] != r_rptr[log2_els_p]) &&
                       (r_wptr[log2_els_p-1:0] == r_rptr[log2_els_p-1:0]);
    assign w_wr      = w_v_i & ~w_full_o;
    assign w_rd      = r_yumi_i & ~r_empty_o;
    assign r_data_o  = r_mem[r_rptr[log2_els_p-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + ONE_C;
            if (w_rd) r_rptr <= r_rptr + ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[log2_els_p-1:0]] <= w_data_i;
    end
endmodule

// File: rtl/flowid_allocator.sv
// Purpose: flow-ID allocator, fresh IDs in order then recycled via free list; FLOWID_ALLOC_CHECK_EN adds in-use bitmap checking.
// Latency: alloc offer is combinational (0 cycles); a returned ID can be reissued from the next cycle; ret_err one cycle late.
// Backpressure: alloc_id holds while alloc_rdy=0; ret_rdy drops only if the free list is full.
module flowid_allocator
    import tcp_pkg::*;
#(
    parameter int FLOWID_W    = TCP_FLOWID_W,
    parameter int NUM_FLOWIDS = 2**FLOWID_W
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                alloc_val,
    output logic [FLOWID_W-1:0] alloc_id,
    input  logic                alloc_rdy,
    input  logic                ret_val,
    input  logic [FLOWID_W-1:0] ret_id,
    output logic                ret_rdy,
    output logic [FLOWID_W:0]   inuse_cnt,
    output logic                ret_err
);
    localparam logic [FLOWID_W:0] NUM_C = (FLOWID_W+1)'(NUM_FLOWIDS);
    localparam logic [FLOWID_W:0] ONE_C = (FLOWID_W+1)'(1);

    logic [FLOWID_W:0]   r_fresh_ctr;
    logic [FLOWID_W:0]   r_inuse_cnt;
    logic                w_fresh_mode;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [FLOWID_W-1:0] w_fifo_head;
    logic                w_alloc_hs;
    logic                w_ret_hs;
    logic                w_reject;
    logic                w_push;
    logic                w_pop;

    // The counter saturates at NUM_FLOWIDS, so fresh mode is left for good.
    assign w_fresh_mode = (r_fresh_ctr < NUM_C);
    assign alloc_val    = w_fresh_mode | ~w_fifo_empty;
    assign alloc_id     = w_fresh_mode ? r_fresh_ctr[FLOWID_W-1:0] : w_fifo_head;
    assign ret_rdy      = ~w_fifo_full;
    assign inuse_cnt    = r_inuse_cnt;

    assign w_alloc_hs = alloc_val & alloc_rdy;
    assign w_ret_hs   = ret_val & ret_rdy;
    assign w_push     = w_ret_hs & ~w_reject;
    assign w_pop      = w_alloc_hs & ~w_fresh_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fresh_ctr <= '0;
            r_inuse_cnt <= '0;
        end else begin
            if (w_alloc_hs && w_fresh_mode) r_fresh_ctr <= r_fresh_ctr + ONE_C;
            if (w_alloc_hs && !w_push)
                r_inuse_cnt <= r_inuse_cnt + ONE_C;
            else if (!w_alloc_hs && w_push && (r_inuse_cnt != '0))
                r_inuse_cnt <= r_inuse_cnt - ONE_C;
        end
    end

`ifdef FLOWID_ALLOC_CHECK_EN
    // Sized to the full ID space so any ret_id indexes it; bits at or above
    // NUM_FLOWIDS are never set and the range test rejects those IDs anyway.
    logic [2**FLOWID_W-1:0] r_bitmap;
    logic                   r_ret_err;
    logic                   w_in_range;

    assign w_in_range = ({1'b0, ret_id} < NUM_C);
    assign w_reject   = ~(w_in_range & r_bitmap[ret_id]);
    assign ret_err    = r_ret_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitmap  <= '0;
            r_ret_err <= 1'b0;
        end else begin
            r_ret_err <= w_ret_hs & w_reject;
            if (w_push)     r_bitmap[ret_id]   <= 1'b0;
            if (w_alloc_hs) r_bitmap[alloc_id] <= 1'b1;
        end
    end
`else
    assign w_reject = 1'b0;
    assign ret_err  = 1'b0;
`endif

    fifo_1r1w #(
        .width_p   (FLOWID_W),
        .log2_els_p(FLOWID_W)
    ) u_free_list (
        .clk      (clk),
        .rst      (~rst_n),
        .w_v_i    (w_push),
        .w_data_i (ret_id),
        .w_full_o (w_fifo_full),
        .r_yumi_i (w_pop),
        .r_data_o (w_fifo_head),
        .r_empty_o(w_fifo_empty)
    );
endmodule

// File: tb/tb_flowid_allocator.sv
// Directed bench for flowid_allocator with FLOWID_W=3, NUM_FLOWIDS=4 (leaves room for out-of-range IDs).
module tb_flowid_allocator;
    localparam int W = 3;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alloc_val;
    logic [W-1:0] alloc_id;
    logic         alloc_rdy;
    logic         ret_val;
    logic [W-1:0] ret_id;
    logic         ret_rdy;
    logic [W:0]   inuse_cnt;
    logic         ret_err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    flowid_allocator #(.FLOWID_W(W), .NUM_FLOWIDS(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc_val(alloc_val),
        .alloc_id (alloc_id),
        .alloc_rdy(alloc_rdy),
        .ret_val  (ret_val),
        .ret_id   (ret_id),
        .ret_rdy  (ret_rdy),
        .inuse_cnt(inuse_cnt),
        .ret_err  (ret_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; alloc_rdy = 1'b0; ret_val = 1'b0; ret_id = '0;
        #1;
        check("rst_alloc_val", alloc_val, 1'b1);
        check("rst_alloc_id", alloc_id, 3'd0);
        check("rst_ret_rdy", ret_rdy, 1'b1);
        check("rst_inuse", inuse_cnt, 4'd0);
        check("rst_ret_err", ret_err, 1'b0);
        tick; tick;
        rst_n = 1'b1;

        // Stall in fresh mode: offer must hold at ID 0.
        for (int i = 0; i < 5; i++) begin
            check("stall_val", alloc_val, 1'b1);
            check("stall_id", alloc_id, 3'd0);
            check("stall_inuse", inuse_cnt, 4'd0);
            tick;
        end

        // Fresh allocation 0..3 back to back.
        alloc_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            check("fresh_val", alloc_val, 1'b1);
            check("fresh_id", alloc_id, 3'(i));
            check("fresh_inuse", inuse_cnt, 4'(i));
            tick;
        end
        check("exhaust_val", alloc_val, 1'b0);
        check("exhaust_inuse", inuse_cnt, 4'd4);

        // Return 2 then 0, then reallocate both.
        alloc_rdy = 1'b0; ret_val = 1'b1; ret_id = 3'd2;
        check("ret2_val", alloc_val, 1'b0);
        check("ret2_inuse", inuse_cnt, 4'd4);
        tick;
        ret_id = 3'd0;
        check("ret0_val", alloc_val, 1'b1);
        check("ret0_id", alloc_id, 3'd2);
        check("ret0_inuse", inuse_cnt, 4'd3);
        tick;
        ret_val = 1'b0; alloc_rdy = 1'b1;
        check("realloc2_id", alloc_id, 3'd2);
        check("realloc2_inuse", inuse_cnt, 4'd2);
        tick;
        check("realloc0_id", alloc_id, 3'd0);
        check("realloc0_inuse", inuse_cnt, 4'd3);
        tick;
        check("realloc_done_val", alloc_val, 1'b0);
        check("realloc_done_inuse", inuse_cnt, 4'd4);

        // Return 3, then allocate 3 while returning 1 in the same cycle.
        alloc_rdy = 1'b0; ret_val = 1'b1; ret_id = 3'd3;
        tick;
        check("ret3_inuse", inuse_cnt, 4'd3);
        check("ret3_id", alloc_id, 3'd3);
        alloc_rdy = 1'b1; ret_id = 3'd1;
        tick;
        ret_val = 1'b0; alloc_rdy = 1'b0;
        check("simul_inuse", inuse_cnt, 4'd3);
        check("simul_val", alloc_val, 1'b1);
        check("simul_next_id", alloc_id, 3'd1);
        check("simul_ret_err", ret_err, 1'b0);
        alloc_rdy = 1'b1;
        tick;
        alloc_rdy = 1'b0;
        check("all_used_val", alloc_val, 1'b0);
        check("all_used_inuse", inuse_cnt, 4'd4);

        // Legal return of 1 (all IDs in use beforehand).
        ret_val = 1'b1; ret_id = 3'd1;
        tick;
        ret_val = 1'b0;
        check("legal_ret_err", ret_err, 1'b0);
        check("legal_ret_inuse", inuse_cnt, 4'd3);
`ifdef FLOWID_ALLOC_CHECK_EN
        // Double-free of 1, then out-of-range 5: both rejected.
        ret_val = 1'b1; ret_id = 3'd1;
        check("dbl_ret_rdy", ret_rdy, 1'b1);
        tick;
        ret_id = 3'd5;
        check("dbl_ret_err", ret_err, 1'b1);
        check("dbl_inuse", inuse_cnt, 4'd3);
        tick;
        ret_val = 1'b0;
        check("oor_ret_err", ret_err, 1'b1);
        check("oor_inuse", inuse_cnt, 4'd3);
        tick;
        check("err_clear", ret_err, 1'b0);
        check("err_clear_inuse", inuse_cnt, 4'd3);
`endif
        // Exactly one entry (ID 1) sits on the free list.
        check("one_free_val", alloc_val, 1'b1);
        check("one_free_id", alloc_id, 3'd1);
        alloc_rdy = 1'b1;
        tick;
        alloc_rdy = 1'b0;
        check("no_dup_val", alloc_val, 1'b0);
        check("no_dup_inuse", inuse_cnt, 4'd4);

        // Bring in-use down to 3, then reset mid-stream.
        ret_val = 1'b1; ret_id = 3'd2;
        tick;
        ret_val = 1'b0;
        check("pre_rst_inuse", inuse_cnt, 4'd3);
        alloc_rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_inuse", inuse_cnt, 4'd0);
        check("mid_rst_id", alloc_id, 3'd0);
        check("mid_rst_val", alloc_val, 1'b1);
        tick;
        rst_n = 1'b1;
        check("post_rst_id0", alloc_id, 3'd0);
        tick;
        check("post_rst_id1", alloc_id, 3'd1);
        check("post_rst_inuse", inuse_cnt, 4'd1);
        tick;
        alloc_rdy = 1'b0;
        check("post_rst_inuse2", inuse_cnt, 4'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
